// File: rtl/bp_pkg.sv
// Shared types and saturating-counter helpers for the branch history table.
// Helpers work on a wide container; callers truncate to their own counter width.
package bp_pkg;

  localparam int CTR_W_MAX = 16;

  typedef enum logic {BHT_IDLE, BHT_CLEAR} bht_state_e;

  // Weakly not-taken: MSB clear, all lower bits set.
  function automatic logic [CTR_W_MAX-1:0] ctr_init(input int ctr_w);
    return CTR_W_MAX'((1 << (ctr_w - 1)) - 1);
  endfunction

  function automatic logic [CTR_W_MAX-1:0] ctr_next(input logic [CTR_W_MAX-1:0] ctr,
                                                    input logic taken,
                                                    input int ctr_w);
    logic [CTR_W_MAX-1:0] max_v;
    max_v = CTR_W_MAX'((1 << ctr_w) - 1);
    if (taken)
      return (ctr == max_v) ? ctr : ctr + CTR_W_MAX'(1);
    else
      return (ctr == '0) ? ctr : ctr - CTR_W_MAX'(1);
  endfunction

endpackage

// File: rtl/bht_sat_update.sv
// Combinational saturating up/down step of one prediction counter.
// Zero latency, no flow control.
module bht_sat_update
  import bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr_nxt
);

  assign ctr_nxt = CTR_W'(ctr_next(CTR_W_MAX'(ctr), taken, CTR_W));

endmodule

// File: rtl/branch_predictor_table.sv
// PC-indexed saturating-counter predictor with training, read bypass and flush sweep.
// Read latency 1 cycle; no backpressure, busy flags the ENTRIES-cycle flush during which inputs are ignored.
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int CTR_W   = 2,
  parameter int PC_W    = 32,
  parameter int IDX_LSB = 2
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            en,
  input  logic [PC_W-1:0] rd_pc,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            flush,
  output logic            pred_taken,
  output logic            pred_valid,
  output logic            busy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] INIT = CTR_W'(ctr_init(CTR_W));
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

  logic [CTR_W-1:0] tbl [ENTRIES];
  bht_state_e       state;
  logic [IDX_W-1:0] clr_ptr;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [CTR_W-1:0] upd_nxt;
  logic [CTR_W-1:0] byp_nxt;
  logic             hit;
  logic             unused_pc_bits;

  assign rd_idx  = rd_pc[IDX_LSB +: IDX_W];
  assign upd_idx = upd_pc[IDX_LSB +: IDX_W];
  assign hit     = upd_valid && (upd_idx == rd_idx);

  // Only the index slice matters; entries alias freely across the rest of the PC.
  assign unused_pc_bits = ^{rd_pc, upd_pc};

  bht_sat_update #(.CTR_W(CTR_W)) u_wr_upd (
    .ctr     (tbl[upd_idx]),
    .taken   (upd_taken),
    .ctr_nxt (upd_nxt)
  );

  bht_sat_update #(.CTR_W(CTR_W)) u_byp_upd (
    .ctr     (tbl[rd_idx]),
    .taken   (upd_taken),
    .ctr_nxt (byp_nxt)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= INIT;
      state      <= BHT_IDLE;
      clr_ptr    <= '0;
      pred_taken <= 1'b0;
      pred_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        BHT_IDLE: begin
          if (flush) begin
            // Flush wins over a same-cycle update; that training is lost.
            state      <= BHT_CLEAR;
            clr_ptr    <= '0;
            busy       <= 1'b1;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
          end else begin
            if (upd_valid) tbl[upd_idx] <= upd_nxt;
            if (en) begin
              pred_valid <= 1'b1;
              pred_taken <= hit ? byp_nxt[CTR_W-1] : tbl[rd_idx][CTR_W-1];
            end else begin
              pred_valid <= 1'b0;
            end
          end
        end
        BHT_CLEAR: begin
          tbl[clr_ptr] <= INIT;
          pred_valid   <= 1'b0;
          pred_taken   <= 1'b0;
          if (clr_ptr == LAST) begin
            state   <= BHT_IDLE;
            busy    <= 1'b0;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + IDX_W'(1);
          end
        end
        default: state <= BHT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Scoreboard bench: default table against a behavioural model, plus a 64x3-bit table for reset-abort and aliasing.
module tb_branch_predictor_table;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 32 entries, 2-bit counters
  logic        a_arst, a_en, a_upd_valid, a_upd_taken, a_flush;
  logic [31:0] a_rd_pc, a_upd_pc;
  logic        a_pred_taken, a_pred_valid, a_busy;

  // Instance B: 64 entries, 3-bit counters
  logic        b_arst, b_en, b_upd_valid, b_upd_taken, b_flush;
  logic [31:0] b_rd_pc, b_upd_pc;
  logic        b_pred_taken, b_pred_valid, b_busy;

  branch_predictor_table #(.ENTRIES(32), .CTR_W(2), .PC_W(32), .IDX_LSB(2)) dut_a (
    .clk(clk), .arst(a_arst), .en(a_en), .rd_pc(a_rd_pc),
    .upd_valid(a_upd_valid), .upd_pc(a_upd_pc), .upd_taken(a_upd_taken),
    .flush(a_flush), .pred_taken(a_pred_taken), .pred_valid(a_pred_valid), .busy(a_busy)
  );

  branch_predictor_table #(.ENTRIES(64), .CTR_W(3), .PC_W(32), .IDX_LSB(2)) dut_b (
    .clk(clk), .arst(b_arst), .en(b_en), .rd_pc(b_rd_pc),
    .upd_valid(b_upd_valid), .upd_pc(b_upd_pc), .upd_taken(b_upd_taken),
    .flush(b_flush), .pred_taken(b_pred_taken), .pred_valid(b_pred_valid), .busy(b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit    vld;
    bit    tkn;
    bit    bsy;
    string tag;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural model of instance A
  int m[32];
  int clr_left = 0;
  bit last_tkn = 1'b0;

  function automatic int sat(input int c, input bit t, input int w);
    if (t) return (c == (1 << w) - 1) ? c : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  task automatic cyc_a(input bit e, input logic [31:0] rp, input bit uv,
                       input logic [31:0] up, input bit ut, input bit fl, input string tag);
    exp_t x;
    int   ri, ui, nv;
    exp_t got;
    a_en = e; a_rd_pc = rp; a_upd_valid = uv; a_upd_pc = up; a_upd_taken = ut; a_flush = fl;
    ri = int'((rp >> 2) & 32'd31);
    ui = int'((up >> 2) & 32'd31);
    x.tag = tag;
    if (clr_left > 0) begin
      clr_left--;
      x.vld = 0; last_tkn = 0;
    end else if (fl) begin
      for (int i = 0; i < 32; i++) m[i] = 1;
      clr_left = 32;
      x.vld = 0; last_tkn = 0;
    end else begin
      nv = uv ? sat(m[ui], ut, 2) : m[ui];
      if (e) begin
        x.vld = 1;
        last_tkn = (uv && ui == ri) ? nv[1] : m[ri][1];
      end else begin
        x.vld = 0;
      end
      if (uv) m[ui] = nv;
    end
    x.tkn = last_tkn;
    x.bsy = (clr_left > 0);
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk({got.tag, "_vld"}, a_pred_valid, got.vld);
    chk({got.tag, "_tkn"}, a_pred_taken, got.tkn);
    chk({got.tag, "_busy"}, a_busy, got.bsy);
  endtask

  task automatic cyc_b(input bit e, input logic [31:0] rp, input bit uv,
                       input logic [31:0] up, input bit ut, input bit fl);
    b_en = e; b_rd_pc = rp; b_upd_valid = uv; b_upd_pc = up; b_upd_taken = ut; b_flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_arst = 1; a_en = 0; a_rd_pc = 0; a_upd_valid = 0; a_upd_pc = 0; a_upd_taken = 0; a_flush = 0;
    b_arst = 1; b_en = 0; b_rd_pc = 0; b_upd_valid = 0; b_upd_pc = 0; b_upd_taken = 0; b_flush = 0;
    for (int i = 0; i < 32; i++) m[i] = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", a_pred_valid, 0);
    chk("rst_tkn", a_pred_taken, 0);
    chk("rst_busy", a_busy, 0);
    @(negedge clk);
    a_arst = 0; b_arst = 0;
    @(posedge clk);
    #1;

    // 1: first read of a fresh entry is weakly not-taken
    cyc_a(1, 32'h40, 0, 0, 0, 0, "t1_read");

    // 2: saturate up, hold, then one step down
    for (int i = 0; i < 4; i++) cyc_a(0, 0, 1, 32'h40, 1, 0, "t2_up");
    cyc_a(1, 32'h40, 0, 0, 0, 0, "t2_sat");
    cyc_a(0, 0, 1, 32'h40, 0, 0, "t2_dn");
    cyc_a(1, 32'h40, 0, 0, 0, 0, "t2_wt");

    // 3: saturate down, hold, one step up; aliased high PC bits share the entry
    for (int i = 0; i < 4; i++) cyc_a(1, 32'h44, 1, 32'h44, 0, 0, "t3_dn");
    cyc_a(0, 0, 1, 32'h1044, 1, 0, "t3_up");
    cyc_a(1, 32'h44, 0, 0, 0, 0, "t3_rd");

    // 4: same-cycle bypass, then training while stalled
    cyc_a(1, 32'h14, 1, 32'h14, 1, 0, "t4_byp");
    cyc_a(0, 32'h14, 1, 32'h14, 1, 0, "t4_stall_up");
    cyc_a(0, 32'h14, 1, 32'h14, 0, 0, "t4_stall_dn1");
    cyc_a(0, 32'h14, 1, 32'h14, 0, 0, "t4_stall_dn2");
    cyc_a(1, 32'h14, 0, 0, 0, 0, "t4_rd");

    // 5: train 8 entries high, flush with a colliding update, inputs ignored during sweep
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 3; k++) cyc_a(0, 0, 1, 32'h20 + 32'(4 * i), 1, 0, "t5_train");
    cyc_a(1, 32'h20, 0, 0, 0, 0, "t5_pre");
    cyc_a(1, 32'h20, 1, 32'h20, 1, 1, "t5_flush");
    for (int i = 0; i < 32; i++)
      cyc_a(1, 32'h20, 1, 32'(4 * (i % 8)) + 32'h20, 1, $urandom_range(0, 1) == 1, "t5_clr");
    for (int i = 0; i < 32; i++) cyc_a(1, 32'(4 * i), 0, 0, 0, 0, "t5_rd");
    for (int i = 0; i < 32; i++) cyc_a(1, 32'(4 * i), 1, 32'(4 * i), 1, 0, "t5_byp");

    // 6: 64x3 table, reset abort mid-sweep, aliasing across bit 8
    for (int i = 20; i < 31; i++)
      for (int k = 0; k < 4; k++) cyc_b(0, 0, 1, 32'(4 * i), 1, 0);
    cyc_b(1, 32'(4 * 25), 0, 0, 0, 0);
    chk("t6_pre_tkn", b_pred_taken, 1);
    cyc_b(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc_b(1, 0, 1, 0, 1, 0);
    chk("t6_mid_busy", b_busy, 1);
    b_arst = 1;
    #1;
    chk("t6_arst_busy", b_busy, 0);
    chk("t6_arst_vld", b_pred_valid, 0);
    @(negedge clk);
    b_arst = 0;
    for (int i = 0; i < 64; i++) begin
      cyc_b(1, 32'(4 * i), 0, 0, 0, 0);
      chk($sformatf("t6_rd%0d", i), {b_pred_valid, b_pred_taken}, 2'b10);
      cyc_b(1, 32'(4 * i), 1, 32'(4 * i), 1, 0);
      chk($sformatf("t6_byp%0d", i), {b_pred_valid, b_pred_taken}, 2'b11);
    end
    cyc_b(0, 0, 1, 32'h100, 1, 0);
    cyc_b(1, 32'h0, 0, 0, 0, 0);
    chk("t6_alias_hi", b_pred_taken, 1);
    cyc_b(0, 0, 1, 32'h0, 0, 0);
    cyc_b(0, 0, 1, 32'h0, 0, 0);
    cyc_b(1, 32'h100, 0, 0, 0, 0);
    chk("t6_alias_lo", b_pred_taken, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
